// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add saturating beat/stall counters.
module fifo_wr_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  BURST_MAX  = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_a_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH+ID_W-1:0]    o_fifo_wr_data,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_almost_full,
    output logic [ID_W-1:0]               o_grant_id,
    output logic                          o_busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]                   o_beat_cnt,
    output logic [31:0]                   o_stall_cnt
`endif
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] grant, grant_n, rr_ptr, rr_ptr_n, pick;
    logic [7:0]      beat_cnt, beat_cnt_n;
    logic            found, open, grant_valid, beat, done;

    // Search starts just after the last grantee so every requester gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign open        = (state == GRANT) && !i_fifo_almost_full && !i_fifo_full;
    assign o_req_ready = {{(NUM_REQ-1){1'b0}}, open} << grant;
    assign grant_valid = i_req_valid[grant];
    assign beat        = grant_valid && open;
    assign o_grant_id  = grant;
    assign o_busy      = (state == GRANT);

    always_comb begin
        done       = (state == GRANT) && (!grant_valid || (beat && beat_cnt == 8'(BURST_MAX - 1)));
        state_n    = (state == IDLE) ? (found ? GRANT : IDLE) : (done ? IDLE : GRANT);
        grant_n    = (state == IDLE && found) ? pick : grant;
        rr_ptr_n   = done ? grant : rr_ptr;
        beat_cnt_n = (state == IDLE) ? 8'd0 : beat_cnt + 8'(beat);
    end

    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state          <= IDLE;
            grant          <= '0;
            rr_ptr         <= ID_W'(NUM_REQ - 1);
            beat_cnt       <= '0;
            o_fifo_wr_en   <= 1'b0;
            o_fifo_wr_data <= '0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            rr_ptr       <= rr_ptr_n;
            beat_cnt     <= beat_cnt_n;
            o_fifo_wr_en <= beat;
            if (beat)
                o_fifo_wr_data <= {grant, i_req_data[grant*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            o_beat_cnt  <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (beat && !(&o_beat_cnt))
                o_beat_cnt <= o_beat_cnt + 32'd1;
            if (state == GRANT && grant_valid && !open && !(&o_stall_cnt))
                o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    assert property (@(posedge i_clk) disable iff (i_a_rst) !(o_fifo_wr_en && i_fifo_full))
        else $error("fifo_wr_arbiter: FIFO written while full");
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of arbitration order, bursts, back-pressure and reset.
// Build with FIFO_WR_ARB_STATS_EN to also check the statistics counters.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  valid = '0;
    logic [31:0] data = '0;
    logic [3:0]  ready;
    logic        wr_en;
    logic [9:0]  wr_data;
    logic        full = 1'b0;
    logic        af = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    int          tests = 0;
    int          fails = 0;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0] beat_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
        .i_clk(clk), .i_a_rst(rst), .i_req_valid(valid), .i_req_data(data),
        .o_req_ready(ready), .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
        .i_fifo_full(full), .i_fifo_almost_full(af), .o_grant_id(grant_id), .o_busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .o_beat_cnt(beat_cnt), .o_stall_cnt(stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        valid = '0;
        full  = 1'b0;
        af    = 1'b0;
        data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %0b exp 0", wr_en); end
        tests++; if (wr_data !== 10'h0) begin fails++; $display("FAIL reset_wr_data: got %0h exp 0", wr_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d exp 0", grant_id); end
        tests++; if (ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %0b exp 0000", ready); end
    endtask

    // Grants 0,1,2,3,0: 4 writes then a 1-cycle arbitration bubble each.
    task automatic test_round_robin;
        logic [1:0] id;
        logic [9:0] exp_d;
        logic       exp_en;
        do_reset;
        valid = 4'hF;
        for (int i = 1; i <= 25; i++) begin
            tick;
            id     = 2'(((i - 1) / 5) % 4);
            exp_en = ((i - 1) % 5) != 0;
            exp_d  = {id, 8'hA0 | {6'd0, id}};
            tests++; if (wr_en !== exp_en) begin fails++; $display("FAIL rr_wr_en[%0d]: got %0b exp %0b", i, wr_en, exp_en); end
            tests++; if (grant_id !== id) begin fails++; $display("FAIL rr_grant_id[%0d]: got %0d exp %0d", i, grant_id, id); end
            tests++; if (busy !== ((i % 5) != 0)) begin fails++; $display("FAIL rr_busy[%0d]: got %0b exp %0b", i, busy, (i % 5) != 0); end
            if (exp_en) begin
                tests++; if (wr_data !== exp_d) begin fails++; $display("FAIL rr_wr_data[%0d]: got %0h exp %0h", i, wr_data, exp_d); end
            end
        end
        valid = '0;
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        valid = 4'hF;
        for (int i = 0; i < 8; i++) tick;
        tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL mid_pre_wr_en: got %0b exp 1", wr_en); end
        rst = 1'b1;
        #1;
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL mid_wr_en: got %0b exp 0", wr_en); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b exp 0", busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL mid_grant_id: got %0d exp 0", grant_id); end
        #1;
        rst = 1'b0;
        tick;
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL mid_regrant: got %0d exp 0", grant_id); end
        tests++; if (ready !== 4'b0001) begin fails++; $display("FAIL mid_ready: got %0b exp 0001", ready); end
        valid = '0;
    endtask

    task automatic test_single_drop;
        do_reset;
        valid = 4'b0100;
        data[23:16] = 8'h11;
        tick;
        tests++; if (ready !== 4'b0100) begin fails++; $display("FAIL drop_ready: got %0b exp 0100", ready); end
        tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL drop_grant_id: got %0d exp 2", grant_id); end
        tick;
        tests++; if (wr_data !== 10'h211 || wr_en !== 1'b1) begin fails++; $display("FAIL drop_w0: got %0b/%0h exp 1/211", wr_en, wr_data); end
        data[23:16] = 8'h22;
        tick;
        tests++; if (wr_data !== 10'h222 || wr_en !== 1'b1) begin fails++; $display("FAIL drop_w1: got %0b/%0h exp 1/222", wr_en, wr_data); end
        valid = '0;
        tick;
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL drop_wr_en: got %0b exp 0", wr_en); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_busy: got %0b exp 0", busy); end
    endtask

    task automatic test_reacquire;
        logic exp_en;
        do_reset;
        valid = 4'b0010;
        for (int i = 1; i <= 7; i++) begin
            tick;
            exp_en = (i >= 2 && i <= 5) || i == 7;
            tests++; if (wr_en !== exp_en) begin fails++; $display("FAIL reacq_wr_en[%0d]: got %0b exp %0b", i, wr_en, exp_en); end
            tests++; if (busy !== (i != 5)) begin fails++; $display("FAIL reacq_busy[%0d]: got %0b exp %0b", i, busy, i != 5); end
        end
        tests++; if (grant_id !== 2'd1) begin fails++; $display("FAIL reacq_grant_id: got %0d exp 1", grant_id); end
        valid = '0;
    endtask

    task automatic test_almost_full;
        do_reset;
        valid = 4'b0001;
        data[7:0] = 8'h33;
        tick;
        tick;
        tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL af_first: got %0b exp 1", wr_en); end
        af = 1'b1;
        #1;
        tests++; if (ready !== 4'b0000) begin fails++; $display("FAIL af_ready: got %0b exp 0000", ready); end
        for (int i = 0; i < 5; i++) begin
            tick;
            tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL af_stall_wr_en[%0d]: got %0b exp 0", i, wr_en); end
            tests++; if (busy !== 1'b1 || grant_id !== 2'd0) begin fails++; $display("FAIL af_hold[%0d]: got %0b/%0d exp 1/0", i, busy, grant_id); end
        end
        af = 1'b0;
        #1;
        tests++; if (ready !== 4'b0001) begin fails++; $display("FAIL af_resume_ready: got %0b exp 0001", ready); end
        for (int i = 0; i < 3; i++) begin
            tick;
            tests++; if (wr_en !== 1'b1 || wr_data !== 10'h033) begin fails++; $display("FAIL af_resume[%0d]: got %0b/%0h exp 1/033", i, wr_en, wr_data); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL af_end_busy: got %0b exp 0", busy); end
        valid = '0;
    endtask

    task automatic test_stall_release;
        do_reset;
        valid = 4'b0001;
        tick;
        full = 1'b1;
        #1;
        tests++; if (ready !== 4'b0000) begin fails++; $display("FAIL full_ready: got %0b exp 0000", ready); end
        tick;
        tests++; if (busy !== 1'b1 || wr_en !== 1'b0) begin fails++; $display("FAIL full_hold: got %0b/%0b exp 1/0", busy, wr_en); end
        valid = '0;
        tick;
        tests++; if (busy !== 1'b0 || wr_en !== 1'b0) begin fails++; $display("FAIL full_release: got %0b/%0b exp 0/0", busy, wr_en); end
        full = 1'b0;
    endtask

    task automatic test_wrap;
        do_reset;
        valid = 4'b1001;
        tick;
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL wrap_first: got %0d exp 0", grant_id); end
        for (int i = 0; i < 5; i++) tick;
        tests++; if (grant_id !== 2'd3 || busy !== 1'b1) begin fails++; $display("FAIL wrap_second: got %0d/%0b exp 3/1", grant_id, busy); end
        tick;
        tests++; if (wr_data !== 10'h3A3) begin fails++; $display("FAIL wrap_data: got %0h exp 3a3", wr_data); end
        valid = '0;
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats;
        int n;
        do_reset;
        valid = 4'b0001;
        tick;
        af = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        af = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            tick;
            if (wr_en) n++;
            if (n == 10) valid = '0;
        end
        tick;
        tests++; if (n !== 10) begin fails++; $display("FAIL stats_writes: got %0d exp 10", n); end
        tests++; if (beat_cnt !== 32'd10) begin fails++; $display("FAIL stats_beat_cnt: got %0d exp 10", beat_cnt); end
        tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL stats_stall_cnt: got %0d exp 3", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_round_robin;
        test_reset_mid_burst;
        test_single_drop;
        test_reacquire;
        test_almost_full;
        test_stall_release;
        test_wrap;
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
